// File: rtl/freq_pkg.sv
// Shared definitions for the frequency meter: FSM state encoding.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/freq_meter_if.sv
// Measurement request/result bundle for freq_meter; master requests, slave measures.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport master (output start, input busy, input done, input count, input ovf);
  modport slave  (input start, output busy, output done, output count, output ovf);
endinterface

// File: rtl/freq_meter_edge_sync.sv
// Input sampling and rising-edge detector for freq_meter.
// FREQ_METER_SYNC_EN selects a two-flop synchronizer ahead of the history flop.
module edge_sync (
  input  logic clk200mhz,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

`ifdef FREQ_METER_SYNC_EN
  logic meta, sync, hist;

  always_ff @(posedge clk200mhz or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
`else
  logic samp, hist;

  always_ff @(posedge clk200mhz or negedge rst_n) begin
    if (!rst_n) begin
      samp <= 1'b0;
      hist <= 1'b0;
    end else begin
      samp <= d;
      hist <= samp;
    end
  end

  assign rise = samp & ~hist;
`endif

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks per start request.
module freq_meter
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk200mhz,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic             edge_ovf, edge_ovf_nxt;
  logic             rise;
  logic             gate_end;

  edge_sync u_edge_sync (
    .clk200mhz (clk200mhz),
    .rst_n     (rst_n),
    .d         (sig_in),
    .rise      (rise)
  );

  assign gate_end = (state == MEASURE) && (gate_cnt == GATE_LAST);

  always_ff @(posedge clk200mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MEASURE;
      MEASURE: if (gate_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MEASURE);
    done = (state == DONE);
  end

  // Edge on the final gate cycle still counts, so the result latches the next-state value.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    edge_ovf_nxt = edge_ovf;
    if (state == MEASURE && rise) begin
      if (edge_cnt == '1) edge_ovf_nxt = 1'b1;
      else                edge_cnt_nxt = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk200mhz or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      edge_ovf <= 1'b0;
      count    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        edge_ovf <= 1'b0;
      end else if (state == MEASURE) begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_cnt_nxt;
        edge_ovf <= edge_ovf_nxt;
      end
      if (gate_end) begin
        count <= edge_cnt_nxt;
        ovf   <= edge_ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: three instances cover default, narrow-counter
// saturation and back-to-back configurations.
`timescale 1ns/1ps
module tb_freq_meter;

  logic clk = 1'b0;
  always #2.5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic sig = 1'b0;
  int   mode = 0;          // 0: static lvl, 1: toggle each clk, 2: period 4
  logic lvl = 1'b0;
  logic [1:0] ph = 2'd0;

  always @(posedge clk) begin
    #1;
    case (mode)
      1:       sig = ~sig;
      2:       begin ph = ph + 2'd1; sig = ph[1]; end
      default: sig = lvl;
    endcase
  end

  freq_meter_if #(.CNT_W(16)) ifa ();
  freq_meter_if #(.CNT_W(4))  ifb ();
  freq_meter_if #(.CNT_W(16)) ifc ();

  freq_meter #(.GATE_CYCLES(1000), .CNT_W(16)) dut_a (
    .clk200mhz(clk), .rst_n(rst_a), .sig_in(sig), .start(ifa.start),
    .busy(ifa.busy), .done(ifa.done), .count(ifa.count), .ovf(ifa.ovf));

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk200mhz(clk), .rst_n(rst_b), .sig_in(sig), .start(ifb.start),
    .busy(ifb.busy), .done(ifb.done), .count(ifb.count), .ovf(ifb.ovf));

  freq_meter #(.GATE_CYCLES(400), .CNT_W(16)) dut_c (
    .clk200mhz(clk), .rst_n(rst_c), .sig_in(sig), .start(ifc.start),
    .busy(ifc.busy), .done(ifc.done), .count(ifc.count), .ovf(ifc.ovf));

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return ifa.done;
      1:       return ifb.done;
      default: return ifc.done;
    endcase
  endfunction

  function automatic logic [15:0] count_of(input int sel);
    case (sel)
      0:       return ifa.count;
      1:       return {12'd0, ifb.count};
      default: return ifc.count;
    endcase
  endfunction

  function automatic logic ovf_of(input int sel);
    case (sel)
      0:       return ifa.ovf;
      1:       return ifb.ovf;
      default: return ifc.ovf;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       ifa.start = v;
      1:       ifb.start = v;
      default: ifc.start = v;
    endcase
  endtask

  // Returns after the sampling edge of the start pulse.
  task automatic pulse_start(input int sel);
    @(posedge clk); #1 set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
  endtask

  // Counts clock edges until done is seen at a negedge, bounded by limit.
  task automatic wait_done(input int sel, input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < limit && !seen) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done_of(sel) === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
    #1;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ifa.done); end
    checks++; if (ifa.count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ifa.count); end
    checks++; if (ifb.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ifb.ovf); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_rate;
    int cyc; bit seen;
    mode = 1;
    repeat (4) @(posedge clk);
    exp_q.push_back('{cnt: 16'd500, ovf: 1'b0});
    pulse_start(0);
    wait_done(0, 1200, cyc, seen);
    checks++;
    if (!seen || cyc + 1 != 1001) begin
      errors++; $display("FAIL rate_latency: got %0d cycles (seen=%0b) expected 1001", cyc + 1, seen);
    end
    e = exp_q.pop_front();
    checks++; if (count_of(0) !== e.cnt) begin errors++; $display("FAIL rate_count: got %0d expected %0d", count_of(0), e.cnt); end
    checks++; if (ovf_of(0) !== e.ovf) begin errors++; $display("FAIL rate_ovf: got %b expected %b", ovf_of(0), e.ovf); end
    @(posedge clk); @(negedge clk);
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL rate_done_pulse: got %b expected 0", ifa.done); end
  endtask

  task automatic test_static;
    int cyc; bit seen;
    for (int unsigned l = 0; l < 2; l++) begin
      mode = 0; lvl = l[0];
      repeat (6) @(posedge clk);
      exp_q.push_back('{cnt: 16'd0, ovf: 1'b0});
      pulse_start(0);
      wait_done(0, 1200, cyc, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || count_of(0) !== e.cnt || ovf_of(0) !== e.ovf)
        begin errors++; $display("FAIL static_%0d: got count %0d ovf %b seen %0b expected %0d/%b", l, count_of(0), ovf_of(0), seen, e.cnt, e.ovf); end
    end
  endtask

  task automatic test_saturate;
    int cyc; bit seen;
    mode = 1;
    repeat (4) @(posedge clk);
    exp_q.push_back('{cnt: 16'd15, ovf: 1'b1});
    pulse_start(1);
    wait_done(1, 300, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || cyc + 1 != 101) begin errors++; $display("FAIL sat_latency: got %0d expected 101", cyc + 1); end
    checks++; if (count_of(1) !== e.cnt) begin errors++; $display("FAIL sat_count: got %0d expected %0d", count_of(1), e.cnt); end
    checks++; if (ovf_of(1) !== e.ovf) begin errors++; $display("FAIL sat_ovf: got %b expected %b", ovf_of(1), e.ovf); end
    mode = 0; lvl = 1'b0;
    repeat (6) @(posedge clk);
    exp_q.push_back('{cnt: 16'd0, ovf: 1'b0});
    pulse_start(1);
    wait_done(1, 300, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || count_of(1) !== e.cnt) begin errors++; $display("FAIL sat_clear_count: got %0d expected %0d", count_of(1), e.cnt); end
    checks++; if (ovf_of(1) !== e.ovf) begin errors++; $display("FAIL sat_clear_ovf: got %b expected %b", ovf_of(1), e.ovf); end
  endtask

  task automatic test_restart_ignored;
    int cyc; bit seen; int extra;
    mode = 1;
    repeat (4) @(posedge clk);
    exp_q.push_back('{cnt: 16'd500, ovf: 1'b0});
    pulse_start(0);
    repeat (9) @(posedge clk);
    #1 ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    wait_done(0, 1200, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || cyc + 11 != 1001) begin errors++; $display("FAIL restart_latency: got %0d expected 1001", cyc + 11); end
    checks++; if (count_of(0) !== e.cnt) begin errors++; $display("FAIL restart_count: got %0d expected %0d", count_of(0), e.cnt); end
    extra = 0;
    repeat (1100) begin
      @(negedge clk);
      if (ifa.done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL restart_extra_done: got %0d pulses expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int cyc; bit seen; int pulses;
    mode = 1;
    pulse_start(0);
    repeat (50) @(posedge clk);
    #1 rst_a = 1'b0;
    #1;
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", ifa.busy); end
    checks++; if (ifa.count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", ifa.count); end
    @(negedge clk) rst_a = 1'b1;
    pulses = 0;
    repeat (1200) begin
      @(negedge clk);
      if (ifa.done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    exp_q.push_back('{cnt: 16'd500, ovf: 1'b0});
    pulse_start(0);
    wait_done(0, 1200, cyc, seen);
    e = exp_q.pop_front();
    checks++; if (!seen || count_of(0) !== e.cnt) begin errors++; $display("FAIL midrst_recover: got %0d expected %0d", count_of(0), e.cnt); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit seen;
    mode = 2;
    repeat (4) @(posedge clk);
    for (int unsigned i = 0; i < 3; i++) exp_q.push_back('{cnt: 16'd100, ovf: 1'b0});
    @(posedge clk); #1 ifc.start = 1'b1;
    for (int unsigned w = 0; w < 3; w++) begin
      wait_done(2, 500, cyc, seen);
      e = exp_q.pop_front();
      if (w > 0) begin
        checks++; if (!seen || cyc != 402) begin errors++; $display("FAIL b2b_period_%0d: got %0d expected 402", w, cyc); end
      end
      checks++; if (!seen || count_of(2) !== e.cnt) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected %0d", w, count_of(2), e.cnt); end
    end
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy %b expected 0", ifc.busy); end
  endtask

  initial begin
    test_reset;
    test_rate;
    test_static;
    test_saturate;
    test_restart_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000, meaning gate window length in clk200mhz cycles (legal range 2..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the edge count result.
REQ-003 SHALL have port clk200mhz, input, 1, the single 200 MHz system clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sig_in, input, 1, the signal under measurement (e.g. the divided clock output of the upstream divider).
REQ-006 SHALL have port start, input, 1, request for one measurement, sampled on clk200mhz.
REQ-007 SHALL have port busy, output, 1, high while a measurement is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-009 SHALL have port count, output, CNT_W, number of sig_in rising edges in the last gate window.
REQ-010 SHALL have port ovf, output, 1, set when the last window's edge count exceeded 2^CNT_W-1.

Function
REQ-011 SHALL implement FSM states IDLE, MEASURE, DONE.
REQ-012 IDLE -> MEASURE SHALL occur on the edge where start=1; the gate counter and edge counter are cleared on that edge.
REQ-013 MEASURE SHALL last exactly GATE_CYCLES cycles, then transition to DONE.
REQ-014 DONE SHALL last one cycle, then return to IDLE.
REQ-015 busy SHALL be 1 in MEASURE and 0 in IDLE and DONE.
REQ-016 done SHALL be 1 only in DONE.
- start sampled at edge k gives done high in cycle k+GATE_CYCLES+1.
REQ-017 A rising edge is one sampled-sig_in 0->1 transition; only edges detected while in MEASURE SHALL be counted.
REQ-018 The edge counter SHALL saturate at 2^CNT_W-1.
- Any further edge in that window SHALL set an internal overflow flag.
- The flag is cleared at window start.
REQ-019 count and ovf SHALL update only on the DONE-entry edge and hold until the next DONE.
REQ-020 start while busy=1 or in DONE SHALL be ignored; no queuing.
REQ-021 start held high continuously SHALL restart a new measurement from each IDLE cycle (back-to-back windows, one idle cycle apart).
REQ-022 The edge-detect history register SHALL keep updating in all states, so an edge straddling window start is counted only if its 0->1 sample pair falls inside MEASURE.

Reset
REQ-023 rst_n low SHALL asynchronously force:
- state IDLE
- busy=0, done=0, count=0, ovf=0
- all counters and sampling flops to 0.
REQ-024 Reset asserted mid-MEASURE SHALL abort the window with no done pulse; after release, no result is produced until a new start.

Configuration
REQ-025 With macro FREQ_METER_SYNC_EN defined, sig_in SHALL pass through a two-flop synchronizer before edge detection, giving 3 cycles from sig_in change to edge detection.
REQ-026 Without FREQ_METER_SYNC_EN, sig_in SHALL be sampled by a single flop (for clk200mhz-synchronous sources), giving 2 cycles of detection latency.
- Counting rules are otherwise identical.

Structure
REQ-027 FSM state encodings (IDLE=2'd0, MEASURE=2'd1, DONE=2'd2) SHALL live in shared package freq_pkg.
REQ-028 The input sampling/synchronizer plus rising-edge detector SHALL be sub-module edge_sync (ports clk200mhz, rst_n, d, rise), instantiated once.
REQ-029 Gate counter width SHALL be $clog2(GATE_CYCLES+1); the edge counter SHALL be CNT_W wide plus the overflow flag.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- sig_in toggling every clk200mhz cycle (100 MHz), GATE_CYCLES=1000, start pulse -> done exactly 1001 cycles after start, count=500, ovf=0 (both macro settings).
- sig_in held 0, then held 1, start -> count=0, ovf=0.
- CNT_W=4, GATE_CYCLES=100, sig_in at 100 MHz -> count=15, ovf=1; next window with sig_in static -> count=0, ovf=0.
- start pulsed again 10 cycles into MEASURE -> single done pulse, timing and count unchanged from a clean run.
- rst_n pulsed low mid-MEASURE -> busy=0, count=0 immediately, no done until a new start.
- start held high, sig_in period 4 cycles, GATE_CYCLES=400 -> done every 402 cycles, count=100 each window.
